// File: rtl/hazard_unit_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_mdu
//  Description : Hazard/forwarding unit for the 5-stage MIPS pipeline with a
//                multi-cycle MULT/DIV busy tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit_mdu #(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             MemToRegM,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             MduOpD,
    input  logic             MfHiLoD,
    input  logic             MduStartE,
    input  logic             MduDivE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MduBusy,
    output logic             MduDone,
    output logic             MduOvr
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT) + 1;

    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [REG_W-1:0]   c_REG_ZERO = '0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mduState_t;

    mduState_t          r_state;
    mduState_t          w_stateNext;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cntNext;
    logic [c_CNT_W-1:0] w_cntLoad;
    logic               r_ovr;
    logic               w_ovrNext;

    // ------------------------------------------------------------------
    // Register-match helpers: r0 never participates in a hazard.
    // ------------------------------------------------------------------
    logic w_matchAeM, w_matchAeW, w_matchBeM, w_matchBeW;
    logic w_matchAdM, w_matchBdM;

    assign w_matchAeM = (RsE != c_REG_ZERO) && (RsE == WriteRegM) && RegWriteM;
    assign w_matchAeW = (RsE != c_REG_ZERO) && (RsE == WriteRegW) && RegWriteW;
    assign w_matchBeM = (RtE != c_REG_ZERO) && (RtE == WriteRegM) && RegWriteM;
    assign w_matchBeW = (RtE != c_REG_ZERO) && (RtE == WriteRegW) && RegWriteW;
    assign w_matchAdM = (RsD != c_REG_ZERO) && (RsD == WriteRegM) && RegWriteM;
    assign w_matchBdM = (RtD != c_REG_ZERO) && (RtD == WriteRegM) && RegWriteM;

    logic [1:0] w_fwdAE;
    logic [1:0] w_fwdBE;

    // The M-stage result is younger than W, so it takes priority.
    assign w_fwdAE = w_matchAeM ? 2'b10 : (w_matchAeW ? 2'b01 : 2'b00);
    assign w_fwdBE = w_matchBeM ? 2'b10 : (w_matchBeW ? 2'b01 : 2'b00);

    // ------------------------------------------------------------------
    // Stall sources
    // ------------------------------------------------------------------
    logic w_lwStall;
    logic w_brStallE;
    logic w_brStallM;
    logic w_brStall;
    logic w_mduStall;
    logic w_stall;
    logic w_busy;
    logic w_cntNz;
    logic w_done;

    assign w_lwStall  = MemToRegE && (RtE != c_REG_ZERO) &&
                        ((RsD == RtE) || (RtD == RtE));
    assign w_brStallE = RegWriteE && (WriteRegE != c_REG_ZERO) &&
                        ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign w_brStallM = MemToRegM && (WriteRegM != c_REG_ZERO) &&
                        ((WriteRegM == RsD) || (WriteRegM == RtD));
    assign w_brStall  = BranchD && (w_brStallE || w_brStallM);

    assign w_busy  = (r_state == BUSY);
    assign w_cntNz = (r_cnt != '0);
    assign w_done  = w_busy && !w_cntNz;

    // In the completion cycle HI/LO is written before the reader reaches E.
    assign w_mduStall = (MduOpD || MfHiLoD) && ((w_busy && w_cntNz) || MduStartE);
    assign w_stall    = w_lwStall || w_brStall || w_mduStall;

    // ------------------------------------------------------------------
    // MDU occupancy tracker
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_ovr   <= w_ovrNext;
        end
    end

    assign w_cntLoad = MduDivE ? c_DIV_LOAD : c_MUL_LOAD;

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_ovrNext   = r_ovr;
        case (r_state)
            IDLE: begin
                if (MduStartE) begin
                    w_stateNext = BUSY;
                    w_cntNext   = w_cntLoad;
                end
            end
            BUSY: begin
                if (!w_cntNz) begin
                    // A start landing on the final cycle chains straight on.
                    if (MduStartE) begin
                        w_cntNext = w_cntLoad;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else begin
                    w_cntNext = r_cnt - c_CNT_ONE;
                    if (MduStartE) begin
                        w_ovrNext = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are held low for the whole time reset is asserted.
    // ------------------------------------------------------------------
    assign StallF    = !reset && w_stall;
    assign StallD    = !reset && w_stall;
    assign FlushE    = !reset && (w_stall || JumpD);
    assign ForwardAD = !reset && w_matchAdM;
    assign ForwardBD = !reset && w_matchBdM;
    assign ForwardAE = reset ? 2'b00 : w_fwdAE;
    assign ForwardBE = reset ? 2'b00 : w_fwdBE;
    assign MduBusy   = !reset && w_busy;
    assign MduDone   = !reset && w_done;
    assign MduOvr    = !reset && r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit_mdu
//  Description : Directed self-checking bench for hazard_unit_mdu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mdu;

    logic       clk;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic       BranchD, JumpD, MduOpD, MfHiLoD, MduStartE, MduDivE;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MduBusy, MduDone, MduOvr;

    int passed = 0;
    int total  = 0;

    hazard_unit_mdu #(.REG_W(5), .MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .BranchD(BranchD), .JumpD(JumpD), .MduOpD(MduOpD), .MfHiLoD(MfHiLoD),
        .MduStartE(MduStartE), .MduDivE(MduDivE),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MduBusy(MduBusy), .MduDone(MduDone), .MduOvr(MduOvr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemToRegE = 0; MemToRegM = 0; BranchD = 0; JumpD = 0;
        MduOpD = 0; MfHiLoD = 0; MduStartE = 0; MduDivE = 0;
    endtask

    logic sawDone;

    initial begin
        clearInputs();
        reset = 1'b1;
        // Outputs that would otherwise be active must stay low during reset.
        RsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1; JumpD = 1'b1;
        #2;
        check("rst_ForwardAE", {6'd0, ForwardAE}, 8'h0);
        check("rst_FlushE", {7'd0, FlushE}, 8'h0);
        check("rst_StallD", {7'd0, StallD}, 8'h0);
        check("rst_MduBusy", {7'd0, MduBusy}, 8'h0);
        check("rst_MduOvr", {7'd0, MduOvr}, 8'h0);

        nextCycle();
        reset = 1'b0;
        clearInputs();

        // 1: M and W both hold r3 -> M wins
        RsE = 5'd3; RtE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1'b1;
        WriteRegW = 5'd3; RegWriteW = 1'b1;
        #1;
        check("fwdAE_Mwins", {6'd0, ForwardAE}, 8'h2);
        check("fwdBE_Mwins", {6'd0, ForwardBE}, 8'h2);
        RegWriteM = 1'b0;
        #1;
        check("fwdAE_W", {6'd0, ForwardAE}, 8'h1);
        RegWriteW = 1'b0;
        #1;
        check("fwdAE_none", {6'd0, ForwardAE}, 8'h0);
        RsD = 5'd3; RegWriteM = 1'b1;
        #1;
        check("fwdAD_M", {7'd0, ForwardAD}, 8'h1);
        check("fwdBD_nomatch", {7'd0, ForwardBD}, 8'h0);

        // 2: r0 never forwards
        clearInputs();
        WriteRegM = 5'd0; RegWriteM = 1'b1; WriteRegW = 5'd0; RegWriteW = 1'b1;
        #1;
        check("fwdAE_r0", {6'd0, ForwardAE}, 8'h0);

        // 3: load-use
        nextCycle();
        clearInputs();
        MemToRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
        #1;
        check("lw_StallF", {7'd0, StallF}, 8'h1);
        check("lw_StallD", {7'd0, StallD}, 8'h1);
        check("lw_FlushE", {7'd0, FlushE}, 8'h1);
        RsD = 5'd0; RtD = 5'd5;
        #1;
        check("lw_RtD_StallD", {7'd0, StallD}, 8'h1);
        nextCycle();
        MemToRegE = 1'b1; RtE = 5'd0; RsD = 5'd0; RtD = 5'd9;
        #1;
        check("lw_r0_StallD", {7'd0, StallD}, 8'h0);
        check("lw_r0_FlushE", {7'd0, FlushE}, 8'h0);

        // 4: branch compare waits for a load in M
        nextCycle();
        clearInputs();
        BranchD = 1'b1; RsD = 5'd7; MemToRegM = 1'b1; WriteRegM = 5'd7; RegWriteM = 1'b1;
        #1;
        check("br_loadM_StallD", {7'd0, StallD}, 8'h1);
        nextCycle();
        MemToRegM = 1'b0; RegWriteM = 1'b0; WriteRegM = 5'd0;
        WriteRegW = 5'd7; RegWriteW = 1'b1;
        #1;
        check("br_W_StallD", {7'd0, StallD}, 8'h0);
        check("br_W_ForwardAD", {7'd0, ForwardAD}, 8'h0);
        RegWriteE = 1'b1; WriteRegE = 5'd7;
        #1;
        check("br_aluE_StallD", {7'd0, StallD}, 8'h1);
        nextCycle();
        clearInputs();
        JumpD = 1'b1;
        #1;
        check("jump_FlushE", {7'd0, FlushE}, 8'h1);
        check("jump_StallD", {7'd0, StallD}, 8'h0);

        // 5: MULT with MFHI waiting in D
        nextCycle();
        clearInputs();
        MduStartE = 1'b1; MfHiLoD = 1'b1;
        #1;
        check("mul_t0_StallD", {7'd0, StallD}, 8'h1);
        check("mul_t0_Busy", {7'd0, MduBusy}, 8'h0);
        nextCycle();
        MduStartE = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check($sformatf("mul_t%0d_StallD", i), {7'd0, StallD}, (i <= 3) ? 8'h1 : 8'h0);
            check($sformatf("mul_t%0d_Busy", i), {7'd0, MduBusy}, (i <= 4) ? 8'h1 : 8'h0);
            check($sformatf("mul_t%0d_Done", i), {7'd0, MduDone}, (i == 4) ? 8'h1 : 8'h0);
            nextCycle();
        end
        MfHiLoD = 1'b0;

        // DIV occupies 32 cycles
        MduStartE = 1'b1; MduDivE = 1'b1;
        nextCycle();
        MduStartE = 1'b0; MduDivE = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            #1;
            check($sformatf("div_t%0d_Busy", i), {7'd0, MduBusy}, (i <= 32) ? 8'h1 : 8'h0);
            check($sformatf("div_t%0d_Done", i), {7'd0, MduDone}, (i == 32) ? 8'h1 : 8'h0);
            nextCycle();
        end

        // Back-to-back MULT: restart in the completion cycle
        MduStartE = 1'b1;
        nextCycle();
        MduStartE = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            MduStartE = (i == 4);
            #1;
            check($sformatf("b2b_t%0d_Busy", i), {7'd0, MduBusy}, (i <= 8) ? 8'h1 : 8'h0);
            check($sformatf("b2b_t%0d_Done", i), {7'd0, MduDone}, (i == 4 || i == 8) ? 8'h1 : 8'h0);
            nextCycle();
        end
        MduStartE = 1'b0;
        #1;
        check("b2b_Ovr", {7'd0, MduOvr}, 8'h0);

        // 6: start while busy with cnt=3 is ignored and flags overrun
        nextCycle();
        MduStartE = 1'b1;
        nextCycle();
        MduDivE = 1'b1;
        #1;
        check("ovr_before", {7'd0, MduOvr}, 8'h0);
        nextCycle();
        MduStartE = 1'b0; MduDivE = 1'b0;
        #1;
        check("ovr_set", {7'd0, MduOvr}, 8'h1);
        nextCycle();
        nextCycle();
        #1;
        check("ovr_done_kept", {7'd0, MduDone}, 8'h1);
        nextCycle();
        #1;
        check("ovr_idle_after", {7'd0, MduBusy}, 8'h0);
        check("ovr_sticky", {7'd0, MduOvr}, 8'h1);

        // Reset in the middle of a DIV drops it asynchronously
        MduStartE = 1'b1; MduDivE = 1'b1;
        nextCycle();
        MduStartE = 1'b0; MduDivE = 1'b0;
        repeat (5) nextCycle();
        #1;
        check("midDiv_Busy", {7'd0, MduBusy}, 8'h1);
        reset = 1'b1;
        #1;
        check("asyncRst_Busy", {7'd0, MduBusy}, 8'h0);
        check("asyncRst_Done", {7'd0, MduDone}, 8'h0);
        check("asyncRst_Ovr", {7'd0, MduOvr}, 8'h0);
        nextCycle();
        reset = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (MduDone || MduBusy) sawDone = 1'b1;
            nextCycle();
        end
        check("postRst_noDone", {7'd0, sawDone}, 8'h0);
        check("postRst_Ovr", {7'd0, MduOvr}, 8'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
